mult_div_unit: RTL

- Iterative multiply/divide unit for the multicycle MIPS datapath; implements mult, multu, div, divu.
- Consumes the A and B register outputs and a start strobe from the control unit.
- Produces the HI/LO register pair that mfhi/mflo write back through the register-file write-data mux.
- Runs one radix-2 step per clock: shift-add for multiply, restoring subtraction for divide.

---
 rtl/mult_div_unit_if.sv | 20 ++
 rtl/mult_div_unit.sv | 101 ++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: control-unit handshake and HI/LO result bus for mult_div_unit.
// The div_zero signal exists only when MD_DIV_ZERO_EN is defined.
interface mult_div_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
`ifdef MD_DIV_ZERO_EN
   logic             div_zero;
   modport master (output start, op, a_in, b_in, input busy, done, hi, lo, div_zero);
   modport slave  (input start, op, a_in, b_in, output busy, done, hi, lo, div_zero);
`else
   modport master (output start, op, a_in, b_in, input busy, done, hi, lo);
   modport slave  (input start, op, a_in, b_in, output busy, done, hi, lo);
`endif
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 mult/multu/div/divu producing HI/LO, WIDTH+3 cycle latency.
// Define MD_DIV_ZERO_EN to short-circuit divide by zero with a div_zero flag.
module mult_div_unit #(parameter int WIDTH = 32) (
   input logic clock,
   input logic reset,
   mult_div_unit_if.slave md
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
   state_t             state, state_nx;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q, opnd, hi_q, lo_q;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;
   logic               neg_lo, neg_hi, is_div, is_sgn, dz_req;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_trial;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign is_div = op_q[1];
   assign is_sgn = ~op_q[0];
   assign a_mag  = (is_sgn && a_q[WIDTH-1]) ? -a_q : a_q;
   assign b_mag  = (is_sgn && b_q[WIDTH-1]) ? -b_q : b_q;
   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
   assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
   assign prod_fix  = neg_lo ? -acc : acc;
   assign quo_fix   = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix   = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

`ifdef MD_DIV_ZERO_EN
   logic dz_q;
   assign dz_req      = md.op[1] && (md.b_in == '0);
   assign md.div_zero = (state == DONE) && dz_q;
`else
   assign dz_req = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = md.start ? (dz_req ? DONE : PREP) : IDLE;
         PREP:    state_nx = ITER;
         ITER:    state_nx = (cnt == CW'(1)) ? FIX : ITER;
         FIX:     state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         opnd   <= '0;
         acc    <= '0;
         cnt    <= '0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
`ifdef MD_DIV_ZERO_EN
         dz_q   <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         if (state == IDLE && md.start) begin
            op_q <= md.op;
            a_q  <= md.a_in;
            b_q  <= md.b_in;
`ifdef MD_DIV_ZERO_EN
            dz_q <= dz_req;
`endif
         end
         if (state == PREP) begin
            neg_lo <= is_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            neg_hi <= is_div ? (is_sgn && a_q[WIDTH-1]) : (is_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]));
            acc    <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
            opnd   <= is_div ? b_mag : a_mag;
            cnt    <= CW'(WIDTH);
         end
         if (state == ITER) begin
            cnt <= cnt - CW'(1);
            acc <= !is_div ? {mul_sum, acc[WIDTH-1:1]} :
                   div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} :
                   {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end
         if (state == FIX) begin
            hi_q <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
         end
      end
   end

   assign md.busy = state != IDLE;
   assign md.done = state == DONE;
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;
endmodule
